ma_stream: RTL and testbench
============================

# ma_stream

Multi-channel, fully handshaked moving-average filter for the CMUL output path. It averages the last 2^WINDOW_LOG2 accepted samples of each of NUM_CH time-interleaved channels and emits one averaged beat per accepted input beat. It sits between the complex-multiply stage and the downstream AXI-Stream consumer. Compared with the single-channel averager, it adds:
- backpressure;
- signed arithmetic with defined rounding;
- per-channel history;
- frame alignment via tlast;
- a synchronous clear.

## Interface
Parameters:
- IN_WIDTH, 71, signed sample width; matches CMUL output width (16*2+3)*2+1.
- NUM_CH, 4, number of interleaved channels, ≥1.
- WINDOW_LOG2, 2, log2 of the window length; WINDOW = 2^WINDOW_LOG2, WINDOW_LOG2 ≥ 1.
- CH_W, max(1, clog2(NUM_CH)), channel index width.

Ports:
- clk, in, 1, clock; all logic rising-edge.
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, enable; low stalls input acceptance.
- clr, in, 1, synchronous clear of filter state (see Operation).
- s_ma_tdata, in, IN_WIDTH, signed input sample.
- s_ma_tvalid, in, 1, input valid.
- s_ma_tlast, in, 1, marks the last beat of a frame.
- s_ma_tready, out, 1, input ready.
- m_ma_tdata, out, IN_WIDTH, signed averaged sample.
- m_ma_tvalid, out, 1, output valid.
- m_ma_tlast, out, 1, tlast of the beat that produced this output.
- m_ma_tuser, out, CH_W, channel index of this output.
- m_ma_tready, in, 1, output ready.

## Operation
- Accept condition: s_ma_tvalid & s_ma_tready. Offer condition: m_ma_tvalid & m_ma_tready.
- s_ma_tready = en & ~rst & ~clr & (~m_ma_tvalid | m_ma_tready). This is a single output register with pass-through ready; there is no skid buffer.
- Channel counter ch:
  - Beats are assigned to channels round-robin, starting at 0.
  - On each accept, ch increments and wraps NUM_CH-1 → 0.
  - An accepted beat with s_ma_tlast=1 forces the next ch to 0, regardless of current value.
- History: NUM_CH × WINDOW signed entries.
  - One write pointer wp (WINDOW_LOG2 bits) is shared by all channels.
  - wp advances (mod WINDOW) when an accepted beat moves ch back to 0, whether by wrap or by tlast.
- Per-channel running sum, width IN_WIDTH+WINDOW_LOG2, signed.
- On accept of sample x for channel c:
  - old = hist[c][wp]
  - sum[c] ← sum[c] + x − old
  - hist[c][wp] ← x
  - output data ← (sum[c] + x − old) >>> WINDOW_LOG2. This is an arithmetic shift, flooring toward −∞, truncated to IN_WIDTH bits.
- The output can never overflow: the magnitude of the sum is at most WINDOW × 2^(IN_WIDTH−1).
- Ramp-up: history resets to zero, so the first WINDOW−1 outputs of each channel are partial sums divided by WINDOW. No separate fill state exists.
- m_ma_tlast and m_ma_tuser are registered alongside the data from the same accepted beat.
- en=0:
  - No accepts occur.
  - A pending output still completes its handshake.
  - All state is held.
- clr=1 (synchronous) zeroes:
  - all sums and history;
  - ch and wp;
  - m_ma_tvalid.
  A beat presented during clr is not accepted. A pending output is discarded.
- rst=1: same effect as clr, and all outputs are also forced to 0.

## Timing
- Latency is 1 cycle: a beat accepted at edge N gives m_ma_tvalid=1 after edge N.
- Throughput is 1 beat/cycle while m_ma_tready=1.
- m_ma_tvalid, m_ma_tdata, m_ma_tlast and m_ma_tuser are stable while m_ma_tvalid=1 & m_ma_tready=0.
- m_ma_tvalid falls after an offer with no accept in the same cycle.
- Accept and offer may occur in the same cycle; the output register is then overwritten with the new beat.
- Reset values: s_ma_tready=0 during rst, m_ma_tvalid=0, m_ma_tdata=0, m_ma_tlast=0, m_ma_tuser=0. On the first cycle after rst deasserts, s_ma_tready=en.
- Read-during-write on hist[c][wp] returns the old entry. A block-RAM implementation must still meet 1-cycle latency, e.g. with a registered read-ahead or distributed RAM.

## Test plan
- NUM_CH=1, WINDOW_LOG2=2, m_ma_tready=1, input 100 on every beat → outputs 25, 50, 75, 100, 100, …; m_ma_tvalid one cycle after each accept.
- NUM_CH=1, input −1 repeated → outputs −1, −1, −1, … (floor); input sequence 3, 0, 0, 0, 0 → 0, 0, 0, 0, 0.
- NUM_CH=4, beats cycling 10, 20, 30, 40, with tlast on every 4th beat:
  - after 4 frames, outputs are 10, 20, 30, 40;
  - m_ma_tuser = 0, 1, 2, 3;
  - m_ma_tlast=1 only on tuser=3.
- NUM_CH=4: tlast on the 2nd beat of a frame → the next beat gets tuser=0 and wp advances; no channel history is corrupted.
- Random m_ma_tready and en throttling, compared against a reference model → no lost or duplicated beats; outputs held stable while stalled; s_ma_tready follows the equation above every cycle.
- clr pulsed mid-stream with s_ma_tvalid=1 →
  - that beat is not accepted;
  - m_ma_tvalid drops next cycle;
  - the next input 100 (WINDOW 4) outputs 25 with tuser=0;
  - rst mid-stream behaves identically and outputs 0.

Source files
------------

// File: rtl/ma_stream.sv
// Multi-channel moving-average filter with AXI-Stream handshake on both sides.
// Averages the last 2^WINDOW_LOG2 samples per interleaved channel, one output per accepted beat.
module ma_stream #(
   parameter int unsigned IN_WIDTH    = 71,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned WINDOW_LOG2 = 2,
   parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic [IN_WIDTH-1:0] s_ma_tdata,
   input  logic                s_ma_tvalid,
   input  logic                s_ma_tlast,
   output logic                s_ma_tready,
   output logic [IN_WIDTH-1:0] m_ma_tdata,
   output logic                m_ma_tvalid,
   output logic                m_ma_tlast,
   output logic [CH_W-1:0]     m_ma_tuser,
   input  logic                m_ma_tready
);

   localparam int unsigned WINDOW = 1 << WINDOW_LOG2;
   localparam int unsigned SUM_W  = IN_WIDTH + WINDOW_LOG2;

   logic [IN_WIDTH-1:0]    hist_q [NUM_CH][WINDOW];
   logic [SUM_W-1:0]       sum_q  [NUM_CH];
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [WINDOW_LOG2-1:0] wp_q, wp_d;

   logic [IN_WIDTH-1:0] old_smp;
   logic [SUM_W-1:0]    cur_sum, new_sum;
   logic [IN_WIDTH-1:0] avg;
   logic                accept, offer, wrap;

   // Single output register; ready passes straight through when it drains.
   assign s_ma_tready = en & ~rst & ~clr & (~m_ma_tvalid | m_ma_tready);
   assign accept      = s_ma_tvalid & s_ma_tready;
   assign offer       = m_ma_tvalid & m_ma_tready;

   always_comb begin
      old_smp = '0;
      cur_sum = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_q == CH_W'(c)) begin
            cur_sum = sum_q[c];
            for (int w = 0; w < WINDOW; w++) begin
               if (wp_q == WINDOW_LOG2'(w)) old_smp = hist_q[c][w];
            end
         end
      end
      new_sum = cur_sum + SUM_W'($signed(s_ma_tdata)) - SUM_W'($signed(old_smp));
      // Arithmetic shift floors toward -inf; the true sum always fits IN_WIDTH after it.
      avg     = IN_WIDTH'($signed(new_sum) >>> WINDOW_LOG2);
      wrap    = s_ma_tlast | (ch_q == CH_W'(NUM_CH - 1));
      ch_d    = wrap ? '0 : ch_q + 1'b1;
      wp_d    = wrap ? wp_q + 1'b1 : wp_q;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sum_q[c] <= '0;
            for (int w = 0; w < WINDOW; w++) hist_q[c][w] <= '0;
         end
         ch_q        <= '0;
         wp_q        <= '0;
         m_ma_tvalid <= 1'b0;
         if (rst) begin
            m_ma_tdata <= '0;
            m_ma_tlast <= 1'b0;
            m_ma_tuser <= '0;
         end
      end else if (accept) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
               sum_q[c] <= new_sum;
               for (int w = 0; w < WINDOW; w++) begin
                  if (wp_q == WINDOW_LOG2'(w)) hist_q[c][w] <= s_ma_tdata;
               end
            end
         end
         ch_q        <= ch_d;
         wp_q        <= wp_d;
         m_ma_tvalid <= 1'b1;
         m_ma_tdata  <= avg;
         m_ma_tlast  <= s_ma_tlast;
         m_ma_tuser  <= ch_q;
      end else if (offer) begin
         m_ma_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ma_stream.sv
// Directed bench for ma_stream: a 4-channel and a 1-channel instance share clock and control.
module tb_ma_stream;

   logic clk, rst, en, clr;

   logic [70:0] s_data4, m_data4;
   logic        s_valid4, s_last4, s_ready4, m_valid4, m_last4, m_ready4;
   logic [1:0]  m_user4;

   logic [70:0] s_data1, m_data1;
   logic        s_valid1, s_last1, s_ready1, m_valid1, m_last1, m_ready1;
   logic [0:0]  m_user1;

   int errors = 0;
   int checks = 0;

   ma_stream #(.IN_WIDTH(71), .NUM_CH(4), .WINDOW_LOG2(2)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .s_ma_tdata(s_data4), .s_ma_tvalid(s_valid4), .s_ma_tlast(s_last4),
      .s_ma_tready(s_ready4), .m_ma_tdata(m_data4), .m_ma_tvalid(m_valid4),
      .m_ma_tlast(m_last4), .m_ma_tuser(m_user4), .m_ma_tready(m_ready4)
   );

   ma_stream #(.IN_WIDTH(71), .NUM_CH(1), .WINDOW_LOG2(2)) dut1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .s_ma_tdata(s_data1), .s_ma_tvalid(s_valid1), .s_ma_tlast(s_last1),
      .s_ma_tready(s_ready1), .m_ma_tdata(m_data1), .m_ma_tvalid(m_valid1),
      .m_ma_tlast(m_last1), .m_ma_tuser(m_user1), .m_ma_tready(m_ready1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [70:0] v(input int x);
      return 71'(x);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; s_valid4 = 1'b1; s_data4 = v(5);
      tick();
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", s_ready4); end
      checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", m_valid4); end
      checks++; if (m_data4 !== v(0)) begin errors++; $display("FAIL rst_data got %0d exp 0", $signed(m_data4)); end
      checks++; if (m_last4 !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", m_last4); end
      checks++; if (m_user4 !== 2'd0) begin errors++; $display("FAIL rst_user got %0d exp 0", m_user4); end
      s_valid4 = 1'b0; rst = 1'b0;
      #1;
      checks++; if (s_ready4 !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", s_ready4); end
      en = 1'b0;
      #1;
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL post_rst_ready_en0 got %b exp 0", s_ready4); end
      en = 1'b1;
   endtask

   task automatic test_single_ch;
      int ramp[6]  = '{25, 50, 75, 100, 100, 100};
      int seq_in[5] = '{3, 0, 0, 0, 0};
      do_clr();
      for (int i = 0; i < 6; i++) begin
         s_valid1 = 1'b1; s_data1 = v(100);
         tick();
         checks++; if (m_valid1 !== 1'b1 || m_data1 !== v(ramp[i])) begin errors++;
            $display("FAIL ch1_ramp[%0d] got v=%b d=%0d exp v=1 d=%0d", i, m_valid1, $signed(m_data1), ramp[i]); end
      end
      s_valid1 = 1'b0;
      tick();
      checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL ch1_valid_fall got %b exp 0", m_valid1); end
      do_clr();
      for (int i = 0; i < 5; i++) begin
         s_valid1 = 1'b1; s_data1 = v(-1);
         tick();
         checks++; if (m_data1 !== v(-1)) begin errors++;
            $display("FAIL ch1_neg1[%0d] got %0d exp -1", i, $signed(m_data1)); end
      end
      s_valid1 = 1'b0;
      do_clr();
      for (int i = 0; i < 5; i++) begin
         s_valid1 = 1'b1; s_data1 = v(seq_in[i]);
         tick();
         checks++; if (m_data1 !== v(0)) begin errors++;
            $display("FAIL ch1_seq3[%0d] got %0d exp 0", i, $signed(m_data1)); end
      end
      s_valid1 = 1'b0;
      do_clr();
      s_valid1 = 1'b1; s_data1 = v(-5);
      tick();
      checks++; if (m_data1 !== v(-2)) begin errors++; $display("FAIL ch1_floor got %0d exp -2", $signed(m_data1)); end
      s_valid1 = 1'b0;
      tick();
   endtask

   task automatic test_interleave;
      int val, f, e;
      do_clr();
      m_ready4 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         val = 10 * (k % 4 + 1);
         f = k / 4;
         e = (val * (f + 1)) / 4;
         s_valid4 = 1'b1; s_data4 = v(val); s_last4 = (k % 4 == 3);
         tick();
         checks++; if (m_data4 !== v(e)) begin errors++;
            $display("FAIL il_data[%0d] got %0d exp %0d", k, $signed(m_data4), e); end
         checks++; if (m_user4 !== 2'(k % 4)) begin errors++;
            $display("FAIL il_user[%0d] got %0d exp %0d", k, m_user4, k % 4); end
         checks++; if (m_last4 !== (k % 4 == 3)) begin errors++;
            $display("FAIL il_last[%0d] got %b exp %b", k, m_last4, (k % 4 == 3)); end
      end
      s_valid4 = 1'b0; s_last4 = 1'b0;
      tick();
   endtask

   task automatic test_early_tlast;
      int din[10]  = '{8, 12, 8, 12, 16, 20, 8, 12, 16, 20};
      bit lst[10]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
      int dexp[10] = '{2, 3, 4, 6, 4, 5, 6, 9, 8, 10};
      int uexp[10] = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3};
      do_clr();
      m_ready4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_valid4 = 1'b1; s_data4 = v(din[i]); s_last4 = lst[i];
         tick();
         checks++; if (m_data4 !== v(dexp[i]) || m_user4 !== 2'(uexp[i]) || m_last4 !== lst[i]) begin
            errors++;
            $display("FAIL early_tlast[%0d] got d=%0d u=%0d l=%b exp d=%0d u=%0d l=%b", i,
                     $signed(m_data4), m_user4, m_last4, dexp[i], uexp[i], lst[i]);
         end
      end
      s_valid4 = 1'b0; s_last4 = 1'b0;
      tick();
   endtask

   task automatic test_backpressure;
      do_clr();
      m_ready4 = 1'b0; s_valid4 = 1'b1; s_data4 = v(40); s_last4 = 1'b0;
      tick();
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== v(10)) begin errors++;
         $display("FAIL bp_first got v=%b d=%0d exp v=1 d=10", m_valid4, $signed(m_data4)); end
      s_data4 = v(44);
      #1;
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL bp_ready_stall got %b exp 0", s_ready4); end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (m_valid4 !== 1'b1 || m_data4 !== v(10) || m_user4 !== 2'd0) begin errors++;
            $display("FAIL bp_hold[%0d] got v=%b d=%0d u=%0d exp v=1 d=10 u=0", i, m_valid4,
                     $signed(m_data4), m_user4); end
      end
      m_ready4 = 1'b1;
      #1;
      checks++; if (s_ready4 !== 1'b1) begin errors++; $display("FAIL bp_ready_pass got %b exp 1", s_ready4); end
      tick();
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== v(11) || m_user4 !== 2'd1) begin errors++;
         $display("FAIL bp_overwrite got v=%b d=%0d u=%0d exp v=1 d=11 u=1", m_valid4,
                  $signed(m_data4), m_user4); end
      s_valid4 = 1'b0;
      tick();
      checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got %b exp 0", m_valid4); end
      en = 1'b0; s_valid4 = 1'b1; s_data4 = v(8);
      #1;
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL en0_ready got %b exp 0", s_ready4); end
      tick();
      checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL en0_no_accept got %b exp 0", m_valid4); end
      en = 1'b1;
      tick();
      checks++; if (m_data4 !== v(2) || m_user4 !== 2'd2) begin errors++;
         $display("FAIL en0_resume got d=%0d u=%0d exp d=2 u=2", $signed(m_data4), m_user4); end
      s_valid4 = 1'b0;
      tick();
   endtask

   task automatic test_throttle;
      int in_idx = 0;
      int out_idx = 0;
      int ch, f, e;
      bit acc, hold, exp_rdy;
      logic [70:0] held_d;
      logic [1:0]  held_u;
      do_clr();
      s_last4 = 1'b0;
      for (int cyc = 0; cyc < 300 && out_idx < 20; cyc++) begin
         en       = (cyc % 5 != 2);
         m_ready4 = (cyc % 3 != 1);
         s_valid4 = (in_idx < 20);
         s_data4  = v(40 * (in_idx % 4 + 1));
         #1;
         exp_rdy = en & (~m_valid4 | m_ready4);
         checks++; if (s_ready4 !== exp_rdy) begin errors++;
            $display("FAIL thr_ready[%0d] got %b exp %b", cyc, s_ready4, exp_rdy); end
         acc = s_valid4 & s_ready4;
         if (m_valid4 && m_ready4) begin
            ch = out_idx % 4;
            f  = (out_idx / 4 > 3) ? 3 : out_idx / 4;
            e  = 10 * (ch + 1) * (f + 1);
            checks++; if (m_data4 !== v(e) || m_user4 !== 2'(ch)) begin errors++;
               $display("FAIL thr_out[%0d] got d=%0d u=%0d exp d=%0d u=%0d", out_idx,
                        $signed(m_data4), m_user4, e, ch); end
            out_idx++;
         end
         hold = m_valid4 & ~m_ready4;
         held_d = m_data4; held_u = m_user4;
         tick();
         if (hold) begin
            checks++; if (m_valid4 !== 1'b1 || m_data4 !== held_d || m_user4 !== held_u) begin
               errors++;
               $display("FAIL thr_stable[%0d] got v=%b d=%0d exp v=1 d=%0d", cyc, m_valid4,
                        $signed(m_data4), $signed(held_d));
            end
         end
         if (acc) in_idx++;
      end
      checks++; if (out_idx != 20) begin errors++; $display("FAIL thr_count got %0d exp 20", out_idx); end
      s_valid4 = 1'b0; en = 1'b1; m_ready4 = 1'b1;
      tick();
   endtask

   task automatic test_clear;
      do_clr();
      m_ready4 = 1'b1; s_last4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid4 = 1'b1; s_data4 = v(100);
         tick();
      end
      checks++; if (m_data4 !== v(25) || m_user4 !== 2'd2) begin errors++;
         $display("FAIL clr_pre got d=%0d u=%0d exp d=25 u=2", $signed(m_data4), m_user4); end
      clr = 1'b1;
      #1;
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", s_ready4); end
      tick();
      clr = 1'b0;
      checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", m_valid4); end
      tick();
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== v(25) || m_user4 !== 2'd0) begin errors++;
         $display("FAIL clr_next got v=%b d=%0d u=%0d exp v=1 d=25 u=0", m_valid4,
                  $signed(m_data4), m_user4); end
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b exp 0", s_ready4); end
      tick();
      rst = 1'b0;
      checks++; if (m_valid4 !== 1'b0 || m_data4 !== v(0) || m_user4 !== 2'd0 || m_last4 !== 1'b0) begin
         errors++;
         $display("FAIL mrst_out got v=%b d=%0d u=%0d l=%b exp all 0", m_valid4, $signed(m_data4),
                  m_user4, m_last4);
      end
      tick();
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== v(25) || m_user4 !== 2'd0) begin errors++;
         $display("FAIL mrst_next got v=%b d=%0d u=%0d exp v=1 d=25 u=0", m_valid4,
                  $signed(m_data4), m_user4); end
      s_valid4 = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clr = 1'b0;
      s_data4 = '0; s_valid4 = 1'b0; s_last4 = 1'b0; m_ready4 = 1'b1;
      s_data1 = '0; s_valid1 = 1'b0; s_last1 = 1'b0; m_ready1 = 1'b1;
      tick();
      test_reset();
      test_single_ch();
      test_interleave();
      test_early_tlast();
      test_backpressure();
      test_throttle();
      test_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
